// File: rtl/radix4_butterfly_pipe.sv
// radix4_butterfly_pipe: two-stage pipelined radix-4 DIT butterfly.
// Complex Q2.FRAC_W data, on-chip N=16 twiddle ROM and per-beat output scaling.
// A valid/ready handshake with a single global advance lets the pipeline stall under backpressure.
// Optional build macro RADIX4_BFLY_SAT_EN: clamp outputs instead of wrapping them, and add a sat_flag output.
module radix4_butterfly_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = DATA_W - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] in_re,
    input  logic [4*DATA_W-1:0] in_im,
    input  logic [1:0]          tw_k,
    input  logic [1:0]          scale,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DATA_W-1:0] out_re,
    output logic [4*DATA_W-1:0] out_im
`ifdef RADIX4_BFLY_SAT_EN
    ,
    output logic                sat_flag
`endif
);

    // Product width after twiddle multiply, combine width, and full multiplier width.
    localparam int PW       = DATA_W + 1;
    localparam int SW       = DATA_W + 3;
    localparam int MW       = 2 * DATA_W + 1;
    localparam int TW_SHIFT = FRAC_W - 14;

    // Quarter-wave-free cosine table in Q2.14; sin(m) is read as cos(m-4).
    function automatic logic signed [15:0] cosRom(input logic [3:0] m);
        logic signed [15:0] c;
        case (m)
            4'd0:    c =  16'sd16384;
            4'd1:    c =  16'sd15137;
            4'd2:    c =  16'sd11585;
            4'd3:    c =  16'sd6270;
            4'd4:    c =  16'sd0;
            4'd5:    c = -16'sd6270;
            4'd6:    c = -16'sd11585;
            4'd7:    c = -16'sd15137;
            4'd8:    c = -16'sd16384;
            4'd9:    c = -16'sd15137;
            4'd10:   c = -16'sd11585;
            4'd11:   c = -16'sd6270;
            4'd12:   c =  16'sd0;
            4'd13:   c =  16'sd6270;
            4'd14:   c =  16'sd11585;
            default: c =  16'sd15137;
        endcase
        return c;
    endfunction

    // Widen a Q2.14 ROM word to the datapath and align it to FRAC_W.
    function automatic logic signed [DATA_W-1:0] twExt(input logic signed [15:0] v);
        logic signed [DATA_W-1:0] w;
        w = DATA_W'(v);
        return w <<< TW_SHIFT;
    endfunction

    // One product term with round-half-up back to FRAC_W fractional bits.
    function automatic logic signed [MW-1:0] rndMul(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
        logic signed [MW-1:0] p;
        p = MW'(a) * MW'(b);
        p = p + (MW'(1) <<< (FRAC_W - 1));
        return p >>> FRAC_W;
    endfunction

    // Rounded arithmetic right shift by the beat's scale; 3 behaves as 2.
    function automatic logic signed [SW-1:0] scaleLane(input logic signed [SW-1:0] v,
                                                       input logic [1:0]           s);
        logic signed [SW-1:0] r;
        case (s)
            2'd0:    r = v;
            2'd1:    r = (v + SW'(1)) >>> 1;
            default: r = (v + SW'(2)) >>> 2;
        endcase
        return r;
    endfunction

`ifdef RADIX4_BFLY_SAT_EN
    // Clamp to the DATA_W range; returns {clamped, value}.
    function automatic logic [DATA_W:0] reduceLane(input logic signed [SW-1:0] v);
        logic [DATA_W:0] r;
        if (v[SW-1:DATA_W-1] == '0 || v[SW-1:DATA_W-1] == '1)
            r = {1'b0, v[DATA_W-1:0]};
        else if (v[SW-1])
            r = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        else
            r = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        return r;
    endfunction
`endif

    logic                     adv;
    logic                     s1Valid_q;
    logic signed [DATA_W-1:0] aRe_q;
    logic signed [DATA_W-1:0] aIm_q;
    logic signed [PW-1:0]     mulRe_q [3];
    logic signed [PW-1:0]     mulIm_q [3];
    logic [1:0]               scale_q;

    logic [3:0]               twIdx   [3];
    logic signed [DATA_W-1:0] twRe    [3];
    logic signed [DATA_W-1:0] twIm    [3];
    logic signed [PW-1:0]     mulRe_d [3];
    logic signed [PW-1:0]     mulIm_d [3];

    logic                     outValid_q;
    logic [4*DATA_W-1:0]      outRe_q;
    logic [4*DATA_W-1:0]      outIm_q;
    logic [4*DATA_W-1:0]      outRe_d;
    logic [4*DATA_W-1:0]      outIm_d;

    logic signed [SW-1:0]     aRe, aIm, pRe, pIm, qRe, qIm, rRe, rIm;
    logic signed [SW-1:0]     yRe [4];
    logic signed [SW-1:0]     yIm [4];

`ifdef RADIX4_BFLY_SAT_EN
    logic                     satFlag_q;
    logic                     satAny_d;
    logic [DATA_W:0]          redRe [4];
    logic [DATA_W:0]          redIm [4];
`endif

    // The whole pipeline moves together whenever the output slot is free or being taken.
    assign adv      = !outValid_q || out_ready;
    assign in_ready = adv;

    // Stage 1: look up W^k, W^2k, W^3k and multiply B, C, D by them.
    always_comb begin
        twIdx[0] = {2'b00, tw_k};
        twIdx[1] = {1'b0, tw_k, 1'b0};
        twIdx[2] = twIdx[0] + twIdx[1];
        for (int i = 0; i < 3; i++) begin
            twRe[i]    = twExt(cosRom(twIdx[i]));
            twIm[i]    = -twExt(cosRom(twIdx[i] - 4'd4));
            mulRe_d[i] = PW'(rndMul(twRe[i], $signed(in_re[(i+1)*DATA_W +: DATA_W]))
                           - rndMul(twIm[i], $signed(in_im[(i+1)*DATA_W +: DATA_W])));
            mulIm_d[i] = PW'(rndMul(twRe[i], $signed(in_im[(i+1)*DATA_W +: DATA_W]))
                           + rndMul(twIm[i], $signed(in_re[(i+1)*DATA_W +: DATA_W])));
        end
    end

    // Stage 1 register: products, the untwiddled A and the beat's scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            aRe_q     <= '0;
            aIm_q     <= '0;
            scale_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                mulRe_q[i] <= '0;
                mulIm_q[i] <= '0;
            end
        end else if (adv) begin
            s1Valid_q <= in_valid;
            aRe_q     <= $signed(in_re[DATA_W-1:0]);
            aIm_q     <= $signed(in_im[DATA_W-1:0]);
            scale_q   <= scale;
            for (int i = 0; i < 3; i++) begin
                mulRe_q[i] <= mulRe_d[i];
                mulIm_q[i] <= mulIm_d[i];
            end
        end
    end

    assign aRe = SW'(aRe_q);
    assign aIm = SW'(aIm_q);
    assign pRe = SW'(mulRe_q[0]);
    assign pIm = SW'(mulIm_q[0]);
    assign qRe = SW'(mulRe_q[1]);
    assign qIm = SW'(mulIm_q[1]);
    assign rRe = SW'(mulRe_q[2]);
    assign rIm = SW'(mulIm_q[2]);

    // Stage 2: radix-4 combine, rounding scale, then narrow back to DATA_W.
    always_comb begin
        outRe_d = '0;
        outIm_d = '0;
        yRe[0] = aRe + pRe + qRe + rRe;
        yIm[0] = aIm + pIm + qIm + rIm;
        yRe[1] = aRe + pIm - qRe - rIm;
        yIm[1] = aIm - pRe - qIm + rRe;
        yRe[2] = aRe - pRe + qRe - rRe;
        yIm[2] = aIm - pIm + qIm - rIm;
        yRe[3] = aRe - pIm - qRe + rIm;
        yIm[3] = aIm + pRe - qIm - rRe;
`ifdef RADIX4_BFLY_SAT_EN
        satAny_d = 1'b0;
        for (int n = 0; n < 4; n++) begin
            redRe[n] = reduceLane(scaleLane(yRe[n], scale_q));
            redIm[n] = reduceLane(scaleLane(yIm[n], scale_q));
            outRe_d[n*DATA_W +: DATA_W] = redRe[n][DATA_W-1:0];
            outIm_d[n*DATA_W +: DATA_W] = redIm[n][DATA_W-1:0];
            satAny_d = satAny_d | redRe[n][DATA_W] | redIm[n][DATA_W];
        end
`else
        for (int n = 0; n < 4; n++) begin
            outRe_d[n*DATA_W +: DATA_W] = DATA_W'(scaleLane(yRe[n], scale_q));
            outIm_d[n*DATA_W +: DATA_W] = DATA_W'(scaleLane(yIm[n], scale_q));
        end
`endif
    end

    // Output register: holds its beat steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outRe_q    <= '0;
            outIm_q    <= '0;
`ifdef RADIX4_BFLY_SAT_EN
            satFlag_q  <= 1'b0;
`endif
        end else if (adv) begin
            outValid_q <= s1Valid_q;
            outRe_q    <= outRe_d;
            outIm_q    <= outIm_d;
`ifdef RADIX4_BFLY_SAT_EN
            satFlag_q  <= s1Valid_q && satAny_d;
`endif
        end
    end

    assign out_valid = outValid_q;
    assign out_re    = outRe_q;
    assign out_im    = outIm_q;
`ifdef RADIX4_BFLY_SAT_EN
    assign sat_flag  = satFlag_q;
`endif

endmodule

// File: tb/tb_radix4_butterfly_pipe.sv
// tb_radix4_butterfly_pipe: directed and randomized bench for radix4_butterfly_pipe.
// Expected beats come from a complex-arithmetic DFT-4 model with trig-derived twiddles.
module tb_radix4_butterfly_pipe;

    localparam int  DATA_W = 16;
    localparam real PI     = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_re;
    logic [63:0] in_im;
    logic [1:0]  tw_k;
    logic [1:0]  scale;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_re;
    logic [63:0] out_im;
`ifdef RADIX4_BFLY_SAT_EN
    logic        sat_flag;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] expRe [$];
    logic [63:0] expIm [$];
    bit          expSat [$];
    bit          holdPending;
    logic [63:0] heldRe;
    logic [63:0] heldIm;
    bit          lastAccepted;
    bit          lastInReady;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    radix4_butterfly_pipe #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .tw_k      (tw_k),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im)
`ifdef RADIX4_BFLY_SAT_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int roundReal(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    function automatic int rndMul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b) + 64'sd8192;
        return int'(p >>> 14);
    endfunction

    // Reference butterfly: Y_n = sum_m X_m * (-j)^(n*m) with X_m = W^(k*m) * input_m.
    function automatic void modelBeat(input logic [63:0] re, input logic [63:0] im,
                                      input logic [1:0] k, input logic [1:0] s,
                                      output logic [63:0] yr, output logic [63:0] yi,
                                      output bit sat);
        int xr [4];
        int xi [4];
        int ar, ai, wr, wi, m, sh, sr, si, v;
        sat = 1'b0;
        yr  = '0;
        yi  = '0;
        for (int p = 0; p < 4; p++) begin
            ar = int'($signed(re[16*p +: 16]));
            ai = int'($signed(im[16*p +: 16]));
            m  = (int'(k) * p) % 16;
            wr = roundReal($cos(2.0 * PI * m / 16.0) * 16384.0);
            wi = -roundReal($sin(2.0 * PI * m / 16.0) * 16384.0);
            if (p == 0) begin
                xr[p] = ar;
                xi[p] = ai;
            end else begin
                xr[p] = rndMul(wr, ar) - rndMul(wi, ai);
                xi[p] = rndMul(wr, ai) + rndMul(wi, ar);
            end
        end
        sh = (s == 2'd3) ? 2 : int'(s);
        for (int n = 0; n < 4; n++) begin
            sr = 0;
            si = 0;
            for (int p = 0; p < 4; p++) begin
                case ((n * p) % 4)
                    0: begin sr += xr[p]; si += xi[p]; end
                    1: begin sr += xi[p]; si -= xr[p]; end
                    2: begin sr -= xr[p]; si -= xi[p]; end
                    default: begin sr -= xi[p]; si += xr[p]; end
                endcase
            end
            for (int c = 0; c < 2; c++) begin
                v = (c == 0) ? sr : si;
                if (sh > 0) v = (v + (1 <<< (sh - 1))) >>> sh;
`ifdef RADIX4_BFLY_SAT_EN
                if (v > 32767) begin
                    v = 32767;
                    sat = 1'b1;
                end else if (v < -32768) begin
                    v = -32768;
                    sat = 1'b1;
                end
`endif
                if (c == 0) yr[16*n +: 16] = v[15:0];
                else        yi[16*n +: 16] = v[15:0];
            end
        end
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic applyStimulus(input bit v, input logic [63:0] re, input logic [63:0] im,
                                 input logic [1:0] k, input logic [1:0] s, input bit rdy);
        in_valid  = v;
        in_re     = re;
        in_im     = im;
        tw_k      = k;
        scale     = s;
        out_ready = rdy;
    endtask

    // One clock: scoreboard bookkeeping at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic [63:0] er;
        logic [63:0] ei;
        bit          es;
        @(negedge clk);
        if (holdPending) begin
            checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("hold_re", out_re, heldRe);
            checkOutput("hold_im", out_im, heldIm);
        end
        holdPending = out_valid && !out_ready;
        heldRe      = out_re;
        heldIm      = out_im;
        lastInReady = in_ready;
        if (out_valid && out_ready) begin
            checkOutput("beat_expected", {63'd0, expRe.size() != 0}, 64'd1);
            if (expRe.size() != 0) begin
                er = expRe.pop_front();
                ei = expIm.pop_front();
                es = expSat.pop_front();
                checkOutput("beat_re", out_re, er);
                checkOutput("beat_im", out_im, ei);
`ifdef RADIX4_BFLY_SAT_EN
                checkOutput("beat_sat", {63'd0, sat_flag}, {63'd0, es});
`endif
            end
        end
        lastAccepted = in_valid && in_ready;
        if (lastAccepted) begin
            modelBeat(in_re, in_im, tw_k, scale, er, ei, es);
            expRe.push_back(er);
            expIm.push_back(ei);
            expSat.push_back(es);
        end
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipe, checking latency and known output values.
    task automatic directedBeat(input string tag, input logic [63:0] re, input logic [63:0] im,
                                input logic [1:0] k, input logic [1:0] s,
                                input logic [63:0] expR, input logic [63:0] expI, input bit expS);
        applyStimulus(1'b1, re, im, k, s, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        tick();
        checkOutput({tag, "_lat2"}, {63'd0, out_valid}, 64'd1);
        checkOutput({tag, "_re"}, out_re, expR);
        checkOutput({tag, "_im"}, out_im, expI);
`ifdef RADIX4_BFLY_SAT_EN
        checkOutput({tag, "_sat"}, {63'd0, sat_flag}, {63'd0, expS});
`else
        if (expS) $display("[TB] %s expects clamping only in the saturating build", tag);
`endif
        tick();
    endtask

    initial begin
        int cyc;
        int beat;
        holdPending  = 1'b0;
        lastAccepted = 1'b0;
        lastInReady  = 1'b0;
        applyStimulus(1'b0, '0, '0, 2'd0, 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("reset_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_re", out_re, 64'd0);
        checkOutput("reset_im", out_im, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        directedBeat("impulse", {48'd0, 16'd1000}, '0, 2'd0, 2'd0,
                     {4{16'd1000}}, '0, 1'b0);
        directedBeat("dc", {4{16'd4096}}, '0, 2'd0, 2'd0,
                     {48'd0, 16'd16384}, '0, 1'b0);
        directedBeat("dc_scale2", {4{16'd4096}}, '0, 2'd0, 2'd2,
                     {48'd0, 16'd4096}, '0, 1'b0);
        directedBeat("twiddle", {32'd0, 16'd16384, 16'd0}, '0, 2'd1, 2'd0,
                     {16'sd6270, -16'sd15137, -16'sd6270, 16'sd15137},
                     {16'sd15137, 16'sd6270, -16'sd15137, -16'sd6270}, 1'b0);
`ifdef RADIX4_BFLY_SAT_EN
        directedBeat("overflow", {4{16'd32767}}, '0, 2'd0, 2'd0,
                     {48'd0, 16'd32767}, '0, 1'b1);
`else
        directedBeat("overflow", {4{16'd32767}}, '0, 2'd0, 2'd0,
                     {48'd0, 16'hFFFC}, '0, 1'b0);
`endif

        $display("[TB] backpressure stream");
        beat = 0;
        cyc  = 0;
        applyStimulus(1'b1, rand64(), rand64(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
        while (beat < 8 && cyc < 40) begin
            out_ready = !(cyc >= 4 && cyc < 7);
            tick();
            if (cyc >= 4 && cyc < 7)
                checkOutput("stall_in_ready", {63'd0, lastInReady}, 64'd0);
            if (lastAccepted) begin
                beat++;
                applyStimulus(beat < 8, rand64(), rand64(), 2'($urandom_range(0, 3)),
                              2'($urandom_range(0, 3)), out_ready);
            end
            cyc++;
        end
        checkOutput("stream_all_accepted", 64'(beat), 64'd8);
        applyStimulus(1'b0, '0, '0, 2'd0, 2'd0, 1'b1);
        for (int i = 0; i < 10 && (expRe.size() != 0 || out_valid); i++) tick();
        checkOutput("stream_drained", 64'(expRe.size()), 64'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand64(), rand64(), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
            tick();
        end
        applyStimulus(1'b0, '0, '0, 2'd0, 2'd0, 1'b1);
        for (int i = 0; i < 10 && (expRe.size() != 0 || out_valid); i++) tick();
        checkOutput("random_drained", 64'(expRe.size()), 64'd0);

        $display("[TB] reset with beats in flight");
        applyStimulus(1'b1, rand64(), rand64(), 2'd1, 2'd0, 1'b1);
        tick();
        applyStimulus(1'b1, rand64(), rand64(), 2'd2, 2'd1, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("inflight_valid", {63'd0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midreset_re", out_re, 64'd0);
        checkOutput("midreset_im", out_im, 64'd0);
        checkOutput("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        expRe.delete();
        expIm.delete();
        expSat.delete();
        holdPending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("post_reset_idle", {63'd0, out_valid}, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
